// File: rtl/imm_enc_pkg.sv
// imm_enc_pkg: shared types, opcodes and range helper for the immediate encoder
package imm_enc_pkg;
  typedef enum logic [2:0] {FMT_I, FMT_S, FMT_B, FMT_U, FMT_J, FMT_LI} fmt_e;
  typedef enum logic [1:0] {IDLE, EMIT, EMIT2} state_e;
  localparam logic [6:0] OP_IMM = 7'b0010011;
  localparam logic [6:0] OP_LUI = 7'b0110111;
  localparam logic [31:0] NOP = 32'h00000013;
  // v fits in an n-bit two's complement field when every bit above n-2 matches the sign
  function automatic logic fits(input logic [63:0] v, input int unsigned n);
    logic [63:0] s;
    s = 64'($signed(v) >>> (n - 1));
    return s == '0 || s == '1;
  endfunction
endpackage

// File: rtl/imm_pack.sv
// imm_pack: combinational RV instruction field packer, no range checking
// ports: fmt_i/op_i/rd_i/rs1_i/rs2_i/f3_i/imm_i in, instr_o out (FMT_LI packs as I)
module imm_pack
  import imm_enc_pkg::*;
(
  input  fmt_e        fmt_i,
  input  logic [6:0]  op_i,
  input  logic [4:0]  rd_i,
  input  logic [4:0]  rs1_i,
  input  logic [4:0]  rs2_i,
  input  logic [2:0]  f3_i,
  input  logic [31:0] imm_i,
  output logic [31:0] instr_o
);
  always_comb begin
    instr_o = fmt_i == FMT_S ? {imm_i[11:5], rs2_i, rs1_i, f3_i, imm_i[4:0], op_i} :
              fmt_i == FMT_B ? {imm_i[12], imm_i[10:5], rs2_i, rs1_i, f3_i, imm_i[4:1], imm_i[11], op_i} :
              fmt_i == FMT_U ? {imm_i[31:12], rd_i, op_i} :
              fmt_i == FMT_J ? {imm_i[20], imm_i[10:1], imm_i[11], imm_i[19:12], rd_i, op_i} :
                               {imm_i[11:0], rs1_i, f3_i, rd_i, op_i};
  end
endmodule

// File: rtl/imm_encoder.sv
// imm_encoder: range-checks an immediate and emits one or two encoded RV instructions
// ports: in_* request (valid/ready), out_* beat stream (valid/ready, instr, last, err)
// IMM_ENC_EXPAND_EN enables the two-beat LUI+ADDI expansion for FMT_LI
module imm_encoder
  import imm_enc_pkg::*;
#(
  parameter int XLEN = 64
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            in_valid,
  output logic            in_ready,
  input  logic [2:0]      in_fmt,
  input  logic [6:0]      in_opcode,
  input  logic [4:0]      in_rd,
  input  logic [4:0]      in_rs1,
  input  logic [4:0]      in_rs2,
  input  logic [2:0]      in_funct3,
  input  logic [6:0]      in_funct7,
  input  logic [XLEN-1:0] in_imm,
  output logic            out_valid,
  input  logic            out_ready,
  output logic [31:0]     out_instr,
  output logic            out_last,
  output logic            out_err
);
`ifdef IMM_ENC_EXPAND_EN
  localparam bit EXPAND = 1'b1;
`else
  localparam bit EXPAND = 1'b0;
`endif
  state_e state_q, state_d;
  logic [31:0] instr_q, instr_d;
  logic last_q, last_d, err_q, err_d, pend_q, pend_d;
  logic [4:0] rd_q, rd_d;
  logic [11:0] lo_q, lo_d;
  logic [XLEN-1:0] sum;
  logic li, f12, f32, lui_ok, two, ok, accept, fire;
  fmt_e fmt, p_fmt;
  logic [6:0] p_op;
  logic [4:0] p_rd, p_rs1;
  logic [2:0] p_f3;
  logic [31:0] p_imm, pack;
  logic unused_f7;
  assign unused_f7 = ^in_funct7;
  // In IDLE the packer builds the first beat from the inputs; afterwards it
  // builds the pending ADDI rd,rd,lo from the captured fields.
  always_comb begin
    fmt = fmt_e'(in_fmt);
    li = fmt == FMT_LI;
    sum = in_imm + XLEN'(12'h800);
    f12 = fits(in_imm, 12);
    f32 = fits(in_imm, 32);
    lui_ok = in_imm[11:0] == '0 && f32;
    two = li && EXPAND && !f12 && !lui_ok && f32 && fits(sum, 32);
    ok = (fmt == FMT_I || fmt == FMT_S) ? f12 :
         fmt == FMT_B ? fits(in_imm, 13) && !in_imm[0] :
         fmt == FMT_J ? fits(in_imm, 21) && !in_imm[0] :
         fmt == FMT_U ? lui_ok :
         li ? f12 || lui_ok || two : 1'b0;
    in_ready = state_q == IDLE;
    out_valid = !in_ready;
    accept = in_valid && in_ready;
    fire = out_valid && out_ready;
    p_fmt = !in_ready ? FMT_I : li ? (f12 ? FMT_I : FMT_U) : fmt;
    p_op = (!in_ready || (li && f12)) ? OP_IMM : li ? OP_LUI : in_opcode;
    p_rd = in_ready ? in_rd : rd_q;
    p_rs1 = !in_ready ? rd_q : li ? 5'd0 : in_rs1;
    p_f3 = (in_ready && !li) ? in_funct3 : 3'd0;
    p_imm = !in_ready ? {{20{lo_q[11]}}, lo_q} : two ? {sum[31:12], 12'b0} : in_imm[31:0];
  end
  imm_pack u_pack (
    .fmt_i  (p_fmt),
    .op_i   (p_op),
    .rd_i   (p_rd),
    .rs1_i  (p_rs1),
    .rs2_i  (in_rs2),
    .f3_i   (p_f3),
    .imm_i  (p_imm),
    .instr_o(pack)
  );
  always_comb begin
    state_d = state_q;
    instr_d = instr_q;
    last_d = last_q;
    err_d = err_q;
    pend_d = pend_q;
    rd_d = rd_q;
    lo_d = lo_q;
    if (accept) begin
      state_d = EMIT;
      instr_d = ok ? pack : NOP;
      last_d = !two;
      err_d = !ok;
      pend_d = two;
      rd_d = in_rd;
      lo_d = in_imm[11:0];
    end else if (fire) begin
      state_d = (state_q == EMIT && pend_q) ? EMIT2 : IDLE;
      instr_d = pend_q ? pack : instr_q;
      last_d = 1'b1;
      err_d = 1'b0;
      pend_d = 1'b0;
    end
  end
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      instr_q <= '0;
      last_q <= 1'b0;
      err_q <= 1'b0;
      pend_q <= 1'b0;
      rd_q <= '0;
      lo_q <= '0;
    end else begin
      state_q <= state_d;
      instr_q <= instr_d;
      last_q <= last_d;
      err_q <= err_d;
      pend_q <= pend_d;
      rd_q <= rd_d;
      lo_q <= lo_d;
    end
  end
  assign out_instr = instr_q;
  assign out_last = last_q;
  assign out_err = err_q;
endmodule

// File: tb/tb_imm_encoder.sv
// tb_imm_encoder: directed scoreboard bench for imm_encoder
module tb_imm_encoder;
  import imm_enc_pkg::*;
  typedef struct {
    logic [31:0] instr;
    logic        last;
    logic        err;
  } beat_t;
  logic clk, rst_n, in_valid, in_ready, out_valid, out_ready, out_last, out_err;
  logic [2:0] in_fmt, in_funct3;
  logic [6:0] in_opcode, in_funct7;
  logic [4:0] in_rd, in_rs1, in_rs2;
  logic [63:0] in_imm;
  logic [31:0] out_instr;
  beat_t q[$];
  int tests = 0;
  int fails = 0;
  string cur = "none";

  imm_encoder #(.XLEN(64)) dut (
    .clk(clk), .rst_n(rst_n),
    .in_valid(in_valid), .in_ready(in_ready), .in_fmt(in_fmt), .in_opcode(in_opcode),
    .in_rd(in_rd), .in_rs1(in_rs1), .in_rs2(in_rs2), .in_funct3(in_funct3),
    .in_funct7(in_funct7), .in_imm(in_imm),
    .out_valid(out_valid), .out_ready(out_ready), .out_instr(out_instr),
    .out_last(out_last), .out_err(out_err)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic exp_ok(input logic [31:0] i);
    q.push_back('{i, 1'b1, 1'b0});
  endtask

  task automatic exp_err();
    q.push_back('{NOP, 1'b1, 1'b1});
  endtask

  task automatic exp_two(input logic [31:0] hi, input logic [31:0] lo);
    q.push_back('{hi, 1'b0, 1'b0});
    q.push_back('{lo, 1'b1, 1'b0});
  endtask

  task automatic send(input string tag, input fmt_e f, input logic [6:0] op, input logic [4:0] rd,
                      input logic [4:0] rs1, input logic [4:0] rs2, input logic [2:0] f3,
                      input logic [63:0] imm);
    int n = 0;
    while (!in_ready && n < 50) begin
      @(negedge clk);
      n++;
    end
    if (!in_ready) begin
      tests++;
      fails++;
      $error("FAIL %s_accept: in_ready stayed 0 for %0d cycles", tag, n);
      return;
    end
    cur = tag;
    in_valid = 1'b1;
    in_fmt = f;
    in_opcode = op;
    in_rd = rd;
    in_rs1 = rs1;
    in_rs2 = rs2;
    in_funct3 = f3;
    in_funct7 = 7'($urandom());
    in_imm = imm;
    @(posedge clk);
    #1;
    in_valid = 1'b0;
    in_fmt = 3'($urandom());
    in_opcode = 7'($urandom());
    in_rd = 5'($urandom());
    in_rs1 = 5'($urandom());
    in_rs2 = 5'($urandom());
    in_funct3 = 3'($urandom());
    in_imm = {$urandom(), $urandom()};
    chk({tag, "_latency"}, 32'(out_valid), 32'd1);
  endtask

  task automatic drain();
    int n = 0;
    while ((q.size() != 0 || !in_ready) && n < 100) begin
      @(negedge clk);
      n++;
    end
    if (q.size() != 0 || !in_ready) begin
      tests++;
      fails++;
      $error("FAIL drain: %0d beats still expected after %0d cycles", q.size(), n);
    end
  endtask

  always @(negedge clk) begin
    if (rst_n && out_valid && out_ready) begin
      if (q.size() == 0) begin
        tests++;
        fails++;
        $error("FAIL %s_extra: observed beat %h expected none", cur, out_instr);
      end else begin
        beat_t b;
        b = q.pop_front();
        chk({cur, "_instr"}, out_instr, b.instr);
        chk({cur, "_last"}, 32'(out_last), 32'(b.last));
        chk({cur, "_err"}, 32'(out_err), 32'(b.err));
      end
    end
  end

  initial begin
    #200000;
    $error("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    rst_n = 1'b0;
    in_valid = 1'b0;
    in_fmt = '0;
    in_opcode = '0;
    in_rd = '0;
    in_rs1 = '0;
    in_rs2 = '0;
    in_funct3 = '0;
    in_funct7 = '0;
    in_imm = '0;
    out_ready = 1'b1;
    repeat (2) @(negedge clk);
    chk("rst_valid", 32'(out_valid), 32'd0);
    chk("rst_instr", out_instr, 32'd0);
    chk("rst_last", 32'(out_last), 32'd0);
    chk("rst_err", 32'(out_err), 32'd0);
    chk("rst_ready", 32'(in_ready), 32'd1);
    @(posedge clk);
    #1 rst_n = 1'b1;

    exp_ok(32'hFFF00093); send("i_neg1", FMT_I, 7'b0010011, 5'd1, 5'd0, 5'd0, 3'd0, -64'sd1);
    exp_ok(32'h7FF00093); send("i_max", FMT_I, 7'b0010011, 5'd1, 5'd0, 5'd0, 3'd0, 64'd2047);
    exp_err();            send("i_over", FMT_I, 7'b0010011, 5'd1, 5'd0, 5'd0, 3'd0, 64'd2048);
    exp_ok(32'h00310263); send("b_4", FMT_B, 7'b1100011, 5'd0, 5'd2, 5'd3, 3'd0, 64'd4);
    exp_err();            send("b_odd", FMT_B, 7'b1100011, 5'd0, 5'd2, 5'd3, 3'd0, 64'd3);
    exp_ok(32'h7E310FE3); send("b_max", FMT_B, 7'b1100011, 5'd0, 5'd2, 5'd3, 3'd0, 64'd4094);
    exp_err();            send("b_over", FMT_B, 7'b1100011, 5'd0, 5'd2, 5'd3, 3'd0, 64'd4096);
    exp_ok(32'h123450B7); send("u_ok", FMT_U, 7'b0110111, 5'd1, 5'd0, 5'd0, 3'd0, 64'h12345000);
    exp_ok(32'h800000B7); send("u_neg", FMT_U, 7'b0110111, 5'd1, 5'd0, 5'd0, 3'd0, 64'hFFFFFFFF80000000);
    exp_err();            send("u_low", FMT_U, 7'b0110111, 5'd1, 5'd0, 5'd0, 3'd0, 64'h1001);
    exp_err();            send("u_big", FMT_U, 7'b0110111, 5'd1, 5'd0, 5'd0, 3'd0, 64'h80000000);
    exp_ok(32'h001000EF); send("j_2k", FMT_J, 7'b1101111, 5'd1, 5'd0, 5'd0, 3'd0, 64'd2048);
    exp_ok(32'hFFFFF0EF); send("j_m2", FMT_J, 7'b1101111, 5'd1, 5'd0, 5'd0, 3'd0, -64'sd2);
    exp_err();            send("j_odd", FMT_J, 7'b1101111, 5'd1, 5'd0, 5'd0, 3'd0, 64'd3);
    exp_ok(32'hFFB00293); send("li_small", FMT_LI, 7'h7F, 5'd5, 5'd9, 5'd9, 3'd7, -64'sd5);
    exp_ok(32'h123452B7); send("li_lui", FMT_LI, 7'h7F, 5'd5, 5'd9, 5'd9, 3'd7, 64'h12345000);
`ifdef IMM_ENC_EXPAND_EN
    exp_two(32'h123452B7, 32'h67828293);
`else
    exp_err();
`endif
    send("li_pair", FMT_LI, 7'h00, 5'd5, 5'd0, 5'd0, 3'd0, 64'h12345678);
`ifdef IMM_ENC_EXPAND_EN
    exp_two(32'h123462B7, 32'h80028293);
`else
    exp_err();
`endif
    send("li_round", FMT_LI, 7'h00, 5'd5, 5'd0, 5'd0, 3'd0, 64'h12345800);
    exp_err(); send("li_ovf", FMT_LI, 7'h00, 5'd5, 5'd0, 5'd0, 3'd0, 64'h7FFFF900);
    exp_err(); send("li_big", FMT_LI, 7'h00, 5'd5, 5'd0, 5'd0, 3'd0, 64'h100000000);
    drain();

    out_ready = 1'b0;
    exp_ok(32'hFE312E23);
    send("s_stall", FMT_S, 7'b0100011, 5'd0, 5'd2, 5'd3, 3'd2, -64'sd4);
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      chk("stall_valid", 32'(out_valid), 32'd1);
      chk("stall_instr", out_instr, 32'hFE312E23);
      chk("stall_ready", 32'(in_ready), 32'd0);
      in_imm = {$urandom(), $urandom()};
      in_rs2 = 5'($urandom());
    end
    @(posedge clk);
    #1 out_ready = 1'b1;
    drain();

    out_ready = 1'b0;
`ifdef IMM_ENC_EXPAND_EN
    q.push_back('{32'h123452B7, 1'b0, 1'b0});
`else
    exp_err();
`endif
    send("rst_mid", FMT_LI, 7'h00, 5'd5, 5'd0, 5'd0, 3'd0, 64'h12345678);
    out_ready = 1'b1;
    @(posedge clk);
    #1 out_ready = 1'b0;
`ifdef IMM_ENC_EXPAND_EN
    chk("mid_beat2_valid", 32'(out_valid), 32'd1);
    chk("mid_beat2_instr", out_instr, 32'h67828293);
`else
    chk("mid_idle_valid", 32'(out_valid), 32'd0);
`endif
    #2 rst_n = 1'b0;
    #1;
    chk("mid_rst_valid", 32'(out_valid), 32'd0);
    chk("mid_rst_instr", out_instr, 32'd0);
    chk("mid_rst_last", 32'(out_last), 32'd0);
    chk("mid_rst_err", 32'(out_err), 32'd0);
    @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk);
    #1;
    chk("post_rst_ready", 32'(in_ready), 32'd1);
    out_ready = 1'b1;
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      chk("post_rst_no_beat", 32'(out_valid), 32'd0);
    end
    chk("queue_empty", 32'(q.size()), 32'd0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule

// File: doc/imm_encoder.md
IMM_ENCODER -- requirements
Module: imm_encoder

Interface
REQ-001 Parameter: XLEN, 64, width of the input immediate; the block SHALL support only 64.
REQ-002 clk  input  1  single clock; all state updates on the rising edge.
REQ-003 rst_n  input  1  reset; asynchronous assert, active-low.
REQ-004 in_valid  input  1  request present.
REQ-005 in_ready  output  1  request accepted when in_valid && in_ready.
REQ-006 in_fmt  input  3  format: FMT_I, FMT_S, FMT_B, FMT_U, FMT_J, FMT_LI.
REQ-007 in_opcode  input  7  opcode field; ignored for FMT_LI.
REQ-008 in_rd, in_rs1, in_rs2  input  5 each  register fields.
REQ-009 in_funct3  input  3; in_funct7  input  7  function fields; funct7 is unused by every format here.
REQ-010 in_imm  input  XLEN  sign-extended byte-offset immediate.
REQ-011 out_valid  output  1  instruction beat present.
REQ-012 out_ready  input  1  beat consumed when out_valid && out_ready.
REQ-013 out_instr  output  32  encoded RV instruction.
REQ-014 out_last  output  1  final beat of the request.
REQ-015 out_err  output  1  immediate out of range; beat carries NOP.

Function
REQ-016 FSM states: IDLE, EMIT, EMIT2; in_ready SHALL be 1 only in IDLE.
REQ-017 Accept in IDLE -> EMIT; out_valid SHALL assert the cycle after accept (latency 1).
REQ-018 EMIT: on out_ready, go to EMIT2 if a second beat is pending, else go to IDLE.
REQ-019 EMIT2: on out_ready, go to IDLE.
REQ-020 While out_valid && !out_ready, out_instr, out_last and out_err SHALL hold stable.
REQ-021 Range checks, all on the full 64-bit immediate:
- I and S: signed-fits 12 bits.
- B: signed-fits 13 bits and imm[0]==0.
- J: signed-fits 21 bits and imm[0]==0.
- U: imm[11:0]==0 and signed-fits 32 bits.
REQ-022 A failed check SHALL produce a single beat: out_instr=32'h00000013, out_err=1, out_last=1.
REQ-023 Packing SHALL be the exact RV32/64 bit scatter for each format, with rd/rs1/rs2/funct3/opcode placed in their standard fields.
REQ-024 FMT_LI, imm signed-fits 12 bits: single beat ADDI rd,x0,imm.
REQ-025 FMT_LI, imm[11:0]==0 and signed-fits 32 bits: single beat LUI rd,imm[31:12].
REQ-026 FMT_LI, other values: hi=(imm+0x800)>>>12 and lo=imm[11:0].
- Emit LUI rd,hi (out_last=0), then ADDI rd,rd,lo (out_last=1).
- Legal only if both imm and imm+0x800 signed-fit 32 bits; otherwise error per REQ-022.
REQ-027 Inputs are sampled only at accept; input changes afterwards SHALL not affect pending beats.

Reset
REQ-028 rst_n low SHALL force: state IDLE, out_valid=0, out_instr=0, out_last=0, out_err=0.
REQ-029 Reset mid-request (EMIT or EMIT2) SHALL discard pending beats; in_ready=1 on the first edge after release.

Configuration
REQ-030 IMM_ENC_EXPAND_EN defined: two-beat LUI+ADDI expansion per REQ-026 is enabled.
REQ-031 IMM_ENC_EXPAND_EN undefined:
- REQ-026 cases error per REQ-022.
- EMIT2 is unreachable and may be removed.
- REQ-024 and REQ-025 are unaffected.

Structure
REQ-032 Package imm_enc_pkg SHALL hold the fmt enum, opcode constants (OP_IMM 7'b0010011, LUI 7'b0110111), NOP constant and state enum.
REQ-033 Sub-module imm_pack SHALL be a combinational field packer (fmt, fields, imm -> instr) with no range logic; it is instantiated once and reused for both beats.

Verification
REQ-034 FMT_I, opcode 0010011, rd=1, rs1=0, f3=0, imm=-1 -> one cycle later: out_instr=32'hFFF00093, out_last=1, out_err=0.
REQ-035 FMT_B, opcode 1100011, rs1=2, rs2=3, f3=0, imm=4 -> out_instr=32'h00310263.
- Same request with imm=3 -> 32'h00000013, out_err=1.
REQ-036 FMT_LI, rd=5, imm=0x12345678, macro defined -> beat1 32'h123452B7 (out_last=0), then beat2 32'h67828293 (out_last=1).
- Same request, macro undefined -> single beat 32'h00000013, out_err=1.
REQ-037 FMT_U, imm=0x1001 -> out_err=1.
- FMT_LI, imm=0x7FFFF900 -> out_err=1 (rounding overflow).
REQ-038 out_ready=0 for 3 cycles during EMIT -> out_instr stable and in_ready=0; release -> accepted beat completes.
REQ-039 rst_n pulsed low between beat1 and beat2 of REQ-036 -> out_valid=0 immediately; in_ready=1 after release; no beat2 emitted.
